spram_arbiter: RTL
==================

// Module: spram_arbiter
// PURPOSE
//  Two-port arbiter sharing one ice40up5k_spram (128 kB, 32-bit) between requesters.
//  Port 0 is the CPU data bus; port 1 is a DMA/peripheral master.
//  Both use the native valid/ready/wstrb memory handshake.
//  Serialises accesses, drives the SPRAM wen/addr/wdata and returns rdata to the granted port.
// PARAMETERS
//  WORDS   32768  SPRAM depth in 32-bit words; must be a power of two
//  ADDR_W  17     byte-address width of requester ports (log2(WORDS*4))
// PORTS
//  clk          in   1       single clock; SPRAM clocked on the same edge
//  resetn       in   1       asynchronous, active-low reset
//  m0_valid     in   1       port 0 request
//  m0_ready     out  1       port 0 one-cycle completion strobe
//  m0_addr      in   ADDR_W  port 0 byte address; bits [1:0] ignored
//  m0_wdata     in   32      port 0 write data
//  m0_wstrb     in   4       port 0 byte strobes; 4'b0000 = read
//  m0_rdata     out  32      port 0 read data, valid while m0_ready
//  m1_*         same set as m0_* for port 1
//  spram_wen    out  4       to ice40up5k_spram.wen
//  spram_addr   out  22      word address to ice40up5k_spram.addr
//  spram_wdata  out  32      to ice40up5k_spram.wdata
//  spram_rdata  in   32      from ice40up5k_spram.rdata; valid 1 cycle after address
// BEHAVIOUR
//  - Reset values
//    - state=IDLE; m0_ready=m1_ready=0; m*_rdata=0.
//    - spram_wen=0, spram_addr=0, spram_wdata=0.
//    - grant=0, last_grant=1.
//  - FSM: IDLE -> ACCESS -> RESP -> IDLE. 3 cycles per access, fixed for reads and writes.
//  - IDLE: sample valids; if any set, register grant (arbitration below) and go to ACCESS.
//    With no valid, stay in IDLE with all SPRAM outputs 0.
//  - ACCESS
//    - spram_addr = {zero-extend, addr_g[ADDR_W-1:2]}; spram_wdata = wdata_g.
//    - spram_wen = wstrb_g. This is the only state in which spram_wen may be nonzero.
//    - Go to RESP.
//  - RESP
//    - Assert ready_g for exactly one cycle; rdata_g = spram_rdata. Set last_grant = grant.
//    - spram_wen=0, addr held. Go to IDLE.
//  - Timing: m_valid high at edge N (sampled in IDLE) -> m_ready high in cycle N+2.
//  - Non-granted port: ready=0, rdata=0. rdata of the granted port is 0 outside RESP.
//  - Requester contract: addr/wdata/wstrb are stable while valid && !ready.
//    Once granted, the access completes even if valid drops, and ready still pulses.
//  - Addresses at or above WORDS*4 alias modulo WORDS*4; only low log2(WORDS) word bits are used.
//  - Write completion: ready pulses in RESP; m_rdata then carries the SPRAM output and is don't-care.
//  - Reset mid-access: the FSM returns to IDLE asynchronously and spram_wen drops to 0 at once.
//    A pending write is either fully committed or not at all. No ready is issued.
// CONFIGURATION
//  - SPRAM_ARB_RR_EN defined: round-robin arbitration.
//    - Both valid in IDLE -> grant the port != last_grant.
//    - First contention after reset goes to port 0.
//  - SPRAM_ARB_RR_EN undefined: fixed priority.
//    - Port 0 wins whenever m0_valid is high in IDLE; port 1 only when m0_valid=0.
//    - last_grant is still maintained but unused.
// TESTING
//  1. Single read, port 0
//     - Preload word 0x0040 = 32'hDEADBEEF.
//     - m0_valid, addr=17'h00100, wstrb=0 -> m0_ready 2 cycles later, m0_rdata=32'hDEADBEEF.
//     - spram_wen=0 throughout.
//  2. Byte write
//     - m1 write addr=17'h00200, wdata=32'h11223344, wstrb=4'b0100.
//     - Then read back the same word (preloaded 32'hAAAAAAAA) -> rdata=32'hAA22AAAA.
//  3. Contention, RR build
//     - Both valid continuously with distinct addresses -> grants 0,1,0,1.
//     - One ready pulse every 3 cycles, never both ready in the same cycle.
//  4. Contention, fixed-priority build
//     - Both valid; m0 re-asserts immediately after each ready -> port 1 starves.
//     - m1 is granted in the first IDLE after m0_valid=0.
//  5. Aliasing
//     - WORDS=32768: write addr=17'h1FFFC with 32'hCAFEF00D -> spram_addr=22'h007FFF.
//     - Read of 17'h1FFFC returns 32'hCAFEF00D.
//  6. Reset in ACCESS of a write
//     - Drive resetn low in ACCESS -> spram_wen=0 within the same cycle, no ready.
//     - After release: state IDLE, and the next access completes normally.

Source files
------------

// File: rtl/spram_arbiter.sv
// Two-port arbiter sharing a single ice40up5k SPRAM; each access takes 3 cycles.
// Define SPRAM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module spram_arbiter #(
  parameter int WORDS  = 32768,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              m0_valid,
  output logic              m0_ready,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_wstrb,
  output logic [31:0]       m0_rdata,
  input  logic              m1_valid,
  output logic              m1_ready,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wstrb,
  output logic [31:0]       m1_rdata,
  output logic [3:0]        spram_wen,
  output logic [21:0]       spram_addr,
  output logic [31:0]       spram_wdata,
  input  logic [31:0]       spram_rdata
);

  localparam int WORD_W = $clog2(WORDS);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state_reg, state_next;
  logic              grant_reg, last_grant_reg, pick;
  logic [WORD_W-1:0] word_reg;
  logic [31:0]       wdata_reg;
  logic [3:0]        wstrb_reg;

  // Only the low word-index bits select a location; the rest alias away.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{m0_addr, m1_addr};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (m0_valid || m1_valid) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef SPRAM_ARB_RR_EN
  assign pick = (m0_valid && m1_valid) ? ~last_grant_reg : ~m0_valid;
`else
  assign pick = ~m0_valid;
`endif

  // Request fields are captured at grant so a dropped valid cannot corrupt the access.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      word_reg       <= '0;
      wdata_reg      <= '0;
      wstrb_reg      <= '0;
    end else begin
      if (state_reg == IDLE && (m0_valid || m1_valid)) begin
        grant_reg <= pick;
        word_reg  <= pick ? m1_addr[WORD_W+1:2] : m0_addr[WORD_W+1:2];
        wdata_reg <= pick ? m1_wdata : m0_wdata;
        wstrb_reg <= pick ? m1_wstrb : m0_wstrb;
      end
      if (state_reg == RESP) last_grant_reg <= grant_reg;
    end
  end

  always_comb begin
    m0_ready    = 1'b0;
    m1_ready    = 1'b0;
    m0_rdata    = '0;
    m1_rdata    = '0;
    spram_wen   = '0;
    spram_addr  = '0;
    spram_wdata = '0;
    case (state_reg)
      ACCESS: begin
        spram_addr  = {{(22-WORD_W){1'b0}}, word_reg};
        spram_wdata = wdata_reg;
        spram_wen   = wstrb_reg;
      end
      RESP: begin
        spram_addr = {{(22-WORD_W){1'b0}}, word_reg};
        if (grant_reg) begin
          m1_ready = 1'b1;
          m1_rdata = spram_rdata;
        end else begin
          m0_ready = 1'b1;
          m0_rdata = spram_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule
